bram_burst_responder: RTL and testbench

Responder end of the burst-read memory interface that the VGA read cache initiates on. It accepts one burst request at a time, emulates SDRAM access latency, and returns a fixed-length burst of 32-bit words from an inferred on-chip block RAM, tagging each word with its byte address. It stands in for the SDRAM controller port in simulation and in SDRAM-less builds, such as boot framebuffers and the test harness. A simple write port loads RAM contents.

---
 rtl/bram_burst_responder.sv | 134 +++++++++++++
 tb/tb_bram_burst_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_burst_responder.sv
// bram_burst_responder: burst-read responder backed by an inferred block RAM.
// Emulates SDRAM latency and returns fixed-length, address-tagged bursts.
module bram_burst_responder #(
    parameter int BURST_WORDS = 16,
    parameter int LATENCY     = 4,
    parameter int ADDR_W      = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sdram_request,
    input  logic [25:0]       sdram_address,
    output logic              sdram_ready,
    output logic              sdram_rvalid,
    output logic [31:0]       sdram_rdata,
    output logic [25:0]       sdram_raddress,
    output logic              sdram_complete,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [31:0]       mem_wdata,
    output logic              busy
);
    localparam int KW = $clog2(BURST_WORDS) + 1;
    localparam int AB = $clog2(BURST_WORDS) + 2;
    localparam logic [25:0] BASE_MASK = ~((26'd1 << AB) - 26'd1);
    localparam logic [KW-1:0] K_LAST = KW'(BURST_WORDS - 1);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WAIT,
        S_READ,
        S_DRAIN
    } state_t;

    state_t            state;
    logic [25:0]       base;
    logic [KW-1:0]     word;
    logic [3:0]        lat_cnt;
    logic [31:0]       mem [2**ADDR_W];
    logic              issue;
    logic              last;
    logic [ADDR_W-1:0] rd_idx;

    // With zero latency the first word is read while ready is pulsed
    assign issue  = (state == S_READ) ||
                    ((state == S_ACCEPT) && (LATENCY == 0));
    assign last   = (word == K_LAST);
    assign rd_idx = base[ADDR_W+1:2] + ADDR_W'(word);

    // RAM write port, open in every state
    always_ff @(posedge clock) begin
        if (mem_write) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Synchronous RAM read; its register is the output data register
    always_ff @(posedge clock) begin
        if (reset) begin
            sdram_rdata <= '0;
        end else if (issue) begin
            sdram_rdata <= mem[rd_idx];
        end
    end

    // Burst sequencer: accept, wait out latency, stream the words
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            base           <= '0;
            word           <= '0;
            lat_cnt        <= '0;
            sdram_ready    <= 1'b0;
            sdram_rvalid   <= 1'b0;
            sdram_raddress <= '0;
            sdram_complete <= 1'b0;
            busy           <= 1'b0;
        end else begin
            sdram_ready    <= 1'b0;
            sdram_rvalid   <= issue;
            sdram_complete <= issue && last;
            if (issue) begin
                sdram_raddress <= base + (26'(word) << 2);
            end
            unique case (state)
                S_IDLE: begin
                    word <= '0;
                    if (sdram_request) begin
                        base        <= sdram_address & BASE_MASK;
                        sdram_ready <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    lat_cnt <= LAT;
                    if (LATENCY == 0) begin
                        if (last) begin
                            state <= S_DRAIN;
                        end else begin
                            word  <= word + KW'(1);
                            state <= S_READ;
                        end
                    end else if (LATENCY == 1) begin
                        state <= S_READ;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd2) begin
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    if (last) begin
                        state <= S_DRAIN;
                    end else begin
                        word <= word + KW'(1);
                    end
                end
                S_DRAIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bram_burst_responder.sv
// tb_bram_burst_responder: cycle-level model plus directed scenarios
// for the block-RAM burst responder.
module tb_bram_burst_responder;
    localparam int L  = 4;
    localparam int B  = 16;
    localparam int AW = 14;

    logic          clock = 1'b0;
    logic          reset;
    logic          sdram_request;
    logic [25:0]   sdram_address;
    logic          sdram_ready;
    logic          sdram_rvalid;
    logic [31:0]   sdram_rdata;
    logic [25:0]   sdram_raddress;
    logic          sdram_complete;
    logic          mem_write;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          busy;

    logic          req0;
    logic [25:0]   addr0;
    logic          ready0;
    logic          rvalid0;
    logic [31:0]   rdata0;
    logic [25:0]   raddr0;
    logic          complete0;
    logic          write0;
    logic [AW-1:0] waddr0;
    logic [31:0]   wdata0;
    logic          busy0;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    bram_burst_responder dut (
        .clock          (clock),
        .reset          (reset),
        .sdram_request  (sdram_request),
        .sdram_address  (sdram_address),
        .sdram_ready    (sdram_ready),
        .sdram_rvalid   (sdram_rvalid),
        .sdram_rdata    (sdram_rdata),
        .sdram_raddress (sdram_raddress),
        .sdram_complete (sdram_complete),
        .mem_write      (mem_write),
        .mem_waddr      (mem_waddr),
        .mem_wdata      (mem_wdata),
        .busy           (busy)
    );

    bram_burst_responder #(
        .BURST_WORDS (1),
        .LATENCY     (0),
        .ADDR_W      (AW)
    ) dut0 (
        .clock          (clock),
        .reset          (reset),
        .sdram_request  (req0),
        .sdram_address  (addr0),
        .sdram_ready    (ready0),
        .sdram_rvalid   (rvalid0),
        .sdram_rdata    (rdata0),
        .sdram_raddress (raddr0),
        .sdram_complete (complete0),
        .mem_write      (write0),
        .mem_waddr      (waddr0),
        .mem_wdata      (wdata0),
        .busy           (busy0)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Timeline model: a burst accepted in cycle T owns cycles T+1..T+1+L+B
    int            cyc = 0;
    int            t_acc = -1000;
    bit            live = 1'b0;
    bit            model_on = 1'b0;
    logic [25:0]   m_base = '0;
    logic [31:0]   shadow [1<<AW];
    logic          e_ready = 1'b0;
    logic          e_valid = 1'b0;
    logic          e_complete = 1'b0;
    logic          e_busy = 1'b0;
    logic [31:0]   e_data = '0;
    logic [25:0]   e_raddr = '0;

    always @(posedge clock) begin : model
        int n;
        int k;
        logic [AW-1:0] idx;
        n = cyc + 1;
        if (reset) begin
            live       = 1'b0;
            e_ready    = 1'b0;
            e_valid    = 1'b0;
            e_complete = 1'b0;
            e_busy     = 1'b0;
            e_data     = '0;
            e_raddr    = '0;
        end else begin
            if ((!live || cyc >= t_acc + 2 + L + B) && sdram_request) begin
                live   = 1'b1;
                t_acc  = cyc;
                m_base = sdram_address & ~26'(4 * B - 1);
            end
            e_ready    = live && (n == t_acc + 1);
            e_busy     = live && (n >= t_acc + 1) && (n <= t_acc + 1 + L + B);
            k          = n - (t_acc + 2 + L);
            e_valid    = live && (k >= 0) && (k < B);
            e_complete = e_valid && (k == B - 1);
            if (e_valid) begin
                idx     = AW'(m_base[25:2] + 24'(k));
                e_data  = shadow[idx];
                e_raddr = m_base + 26'(4 * k);
            end
        end
        if (mem_write) begin
            shadow[mem_waddr] = mem_wdata;
        end
        cyc = n;
    end

    always @(negedge clock) begin
        if (model_on) begin
            chk("m_ready", sdram_ready, e_ready);
            chk("m_rvalid", sdram_rvalid, e_valid);
            chk("m_complete", sdram_complete, e_complete);
            chk("m_busy", busy, e_busy);
            if (e_valid) begin
                chk("m_rdata", sdram_rdata, e_data);
                chk("m_raddress", sdram_raddress, e_raddr);
            end
        end
    end

    task automatic burst_default(input logic [25:0] a);
        sdram_address = a;
        sdram_request = 1'b1;
        step(1);
        chk("ready_T1", sdram_ready, 1);
        sdram_request = 1'b0;
        step(5);
        chk("first_valid", sdram_rvalid, 1);
        chk("first_data", sdram_rdata, 32'hA500_0010);
        chk("first_raddr", sdram_raddress, 26'h40);
        step(15);
        chk("last_complete", sdram_complete, 1);
        chk("last_data", sdram_rdata, 32'hA500_001F);
        chk("last_raddr", sdram_raddress, 26'h7C);
        step(1);
        chk("after_valid", sdram_rvalid, 0);
        chk("after_busy", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        sdram_request = 1'b0;
        sdram_address = '0;
        mem_write = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        req0 = 1'b0;
        addr0 = '0;
        write0 = 1'b0;
        waddr0 = '0;
        wdata0 = '0;
        @(posedge clock);
        #1 model_on = 1'b1;
        step(1);
        chk("rst_ready", sdram_ready, 0);
        chk("rst_rvalid", sdram_rvalid, 0);
        chk("rst_complete", sdram_complete, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", sdram_rdata, 0);
        chk("rst_raddr", sdram_raddress, 0);

        for (int i = 0; i < 64; i++) begin
            mem_write = 1'b1;
            mem_waddr = AW'(i);
            mem_wdata = 32'hA500_0000 + 32'(i);
            write0 = (i < 4);
            waddr0 = AW'(i);
            wdata0 = 32'hA500_0000 + 32'(i);
            step(1);
        end
        mem_write = 1'b0;
        write0 = 1'b0;
        reset = 1'b0;
        step(2);

        burst_default(26'h40);
        step(1);
        burst_default(26'h7B);
        step(1);

        begin
            int pulses;
            int busy_low;
            int last_p;
            int w;
            pulses = 0;
            busy_low = 0;
            last_p = -1;
            sdram_address = 26'h40;
            sdram_request = 1'b1;
            for (int i = 1; i <= 70; i++) begin
                step(1);
                if (sdram_ready) begin
                    if (last_p >= 0) begin
                        chk("ready_period", 32'(i - last_p), 22);
                    end
                    last_p = i;
                    pulses++;
                end
                if (!busy) begin
                    busy_low++;
                end
            end
            chk("ready_count", 32'(pulses), 4);
            chk("busy_gaps", 32'(busy_low), 3);
            sdram_request = 1'b0;
            w = 0;
            while (busy && w < 40) begin
                step(1);
                w++;
            end
            chk("drain_busy", busy, 0);
            step(1);
        end

        sdram_address = 26'h40;
        sdram_request = 1'b1;
        step(1);
        sdram_request = 1'b0;
        step(9);
        chk("rst5_valid", sdram_rvalid, 1);
        chk("rst5_data", sdram_rdata, 32'hA500_0014);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst5_rvalid_off", sdram_rvalid, 0);
        chk("rst5_complete_off", sdram_complete, 0);
        chk("rst5_busy_off", busy, 0);
        chk("rst5_ready_off", sdram_ready, 0);
        step(2);
        burst_default(26'h40);
        step(1);

        sdram_address = 26'h40;
        sdram_request = 1'b1;
        step(1);
        sdram_request = 1'b0;
        step(1);
        mem_write = 1'b1;
        mem_waddr = AW'(14'h18);
        mem_wdata = 32'hDEAD_BEEF;
        step(1);
        mem_write = 1'b0;
        step(10);
        chk("wr_word7", sdram_rdata, 32'hA500_0017);
        step(1);
        chk("wr_word8", sdram_rdata, 32'hDEAD_BEEF);
        chk("wr_word8_addr", sdram_raddress, 26'h60);
        step(8);
        chk("wr_idle", busy, 0);

        addr0 = 26'h001_0004;
        req0 = 1'b1;
        step(1);
        chk("l0_ready", ready0, 1);
        chk("l0_no_valid_yet", rvalid0, 0);
        req0 = 1'b0;
        step(1);
        chk("l0_valid", rvalid0, 1);
        chk("l0_complete", complete0, 1);
        chk("l0_raddr", raddr0, 26'h001_0004);
        chk("l0_data", rdata0, 32'hA500_0001);
        chk("l0_busy", busy0, 1);
        step(1);
        chk("l0_valid_off", rvalid0, 0);
        chk("l0_busy_off", busy0, 0);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
